ept_block_tx: RTL and testbench

Per-module block-transfer transmitter for the Active Transfer interface. It accepts bytes from user logic into a small FIFO and runs a request/grant/byte-acknowledge sequence with the library. It drives one 30-bit `uc_out` slice that feeds the wire-OR stage, and holds that slice at all-zero whenever idle so that several instances can share the OR'd bus.

---
 rtl/ept_block_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ept_block_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ept_block_tx.sv
// ept_block_tx
//
// Block-transfer transmitter for the Active Transfer interface. User logic
// pushes bytes into a small show-ahead FIFO. A start pulse then runs a
// request / grant / per-byte acknowledge sequence with the library. The
// 30-bit uc_out slice feeds a wire-OR bus, so it is held at zero whenever
// this instance is not actively requesting or sending.
//
// Optional feature: define EPT_TX_TIMEOUT_EN to abort a request that is not
// granted within TIMEOUT cycles. Without it, REQ waits forever and timeout
// is constant 0.
//
// Parameters
//   ADDR     module address driven in uc_out[29:27]
//   FIFO_AW  FIFO address width (depth 2**FIFO_AW bytes)
//   TIMEOUT  grant-wait limit in cycles (timeout build only)
//
// Ports
//   CLK, RST           rising-edge clock, asynchronous active-high reset
//   start, length      begin a transfer of length bytes (length sampled on start)
//   wr_en, wr_data     FIFO write port
//   full, overflow     FIFO full; sticky dropped-write flag (cleared by start)
//   busy               FSM not in IDLE
//   lib_grant          library grant level, sampled in REQ
//   lib_ack            library consumed the presented byte (one-cycle pulse)
//   done, timeout      one-cycle completion / abort pulses
//   uc_out             {addr[2:0], req, strobe, last, length[15:0], data[7:0]}

module ept_block_tx #(
    parameter logic [2:0]  ADDR    = 3'd0,
    parameter int          FIFO_AW = 4,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] length,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        overflow,
    output logic        busy,
    input  logic        lib_grant,
    input  logic        lib_ack,
    output logic        done,
    output logic        timeout,
    output logic [29:0] uc_out
);

    localparam int                 DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [FIFO_AW:0]   count, count_d;
    logic               empty, push, pop;
    logic [7:0]         head;

    logic [1:0]  state, state_d;
    logic [15:0] remaining, rem_d;
    logic [15:0] len_q, len_d;
    logic [29:0] uc_d;
    logic        done_d, tout_d, tout_hit;

    assign empty = (count == '0);
    assign head  = mem[rptr];
    // A write while full is still taken when the same edge pops a byte.
    assign push  = wr_en && (!full || pop);

    always_comb begin
        count_d = count;
        case ({push, pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            count <= count_d;
            full  <= (count_d == DEPTH_C);
            if (start && state == S_IDLE)
                overflow <= 1'b0;
            if (wr_en && !push)
                overflow <= 1'b1;
        end
    end

`ifdef EPT_TX_TIMEOUT_EN
    logic [15:0] tcnt;

    assign tout_hit = (tcnt == TIMEOUT - 16'd1);

    // REQ is only ever entered from IDLE, so clearing in IDLE clears on entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            tcnt <= '0;
        else if (state == S_IDLE)
            tcnt <= '0;
        else if (state == S_REQ)
            tcnt <= tcnt + 16'd1;
    end
`else
    assign tout_hit = 1'b0;
`endif

    // uc_out is registered from the current state, so it trails the state
    // register by one edge. An accepted ack blanks the strobe for one cycle,
    // which stops a library from acknowledging the same byte twice.
    always_comb begin
        state_d = state;
        rem_d   = remaining;
        len_d   = len_q;
        uc_d    = '0;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && length != 16'd0) begin
                    state_d = S_REQ;
                    rem_d   = length;
                    len_d   = length;
                end
            end
            S_REQ: begin
                uc_d = {ADDR, 3'b100, len_q, 8'h00};
                if (lib_grant) begin
                    state_d = S_SEND;
                end else if (tout_hit) begin
                    state_d = S_IDLE;
                    uc_d    = '0;
                    tout_d  = 1'b1;
                end
            end
            S_SEND: begin
                if (lib_ack && uc_out[25]) begin
                    pop   = 1'b1;
                    rem_d = remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        uc_d = {ADDR, 3'b000, len_q, 8'h00};
                    end
                end else if (!empty) begin
                    uc_d = {ADDR, 2'b01, (remaining == 16'd1), len_q, head};
                end else begin
                    uc_d = {ADDR, 3'b000, len_q, 8'h00};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            remaining <= '0;
            len_q     <= '0;
            uc_out    <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            remaining <= rem_d;
            len_q     <= len_d;
            uc_out    <= uc_d;
            done      <= done_d;
            timeout   <= tout_d;
            busy      <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ept_block_tx.sv
module tb_ept_block_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] length = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        lib_grant = 1'b0;
    logic        lib_ack = 1'b0;

    logic        full1, overflow1, busy1, done1, timeout1;
    logic [29:0] uc1;

    // second instance never gets any stimulus
    logic        start2 = 1'b0;
    logic [15:0] length2 = '0;
    logic        wr_en2 = 1'b0;
    logic [7:0]  wr_data2 = '0;
    logic        grant2 = 1'b0;
    logic        ack2 = 1'b0;
    logic        full2, overflow2, busy2, done2, timeout2;
    logic [29:0] uc2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];

    always #5 CLK = ~CLK;

    ept_block_tx #(.ADDR(3'd1), .FIFO_AW(4), .TIMEOUT(16'd8)) dut1 (
        .CLK(CLK), .RST(RST), .start(start), .length(length),
        .wr_en(wr_en), .wr_data(wr_data), .full(full1), .overflow(overflow1),
        .busy(busy1), .lib_grant(lib_grant), .lib_ack(lib_ack),
        .done(done1), .timeout(timeout1), .uc_out(uc1)
    );

    ept_block_tx #(.ADDR(3'd2), .FIFO_AW(4), .TIMEOUT(16'd8)) dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .length(length2),
        .wr_en(wr_en2), .wr_data(wr_data2), .full(full2), .overflow(overflow2),
        .busy(busy2), .lib_grant(grant2), .lib_ack(ack2),
        .done(done2), .timeout(timeout2), .uc_out(uc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        check("inst2_idle", 32'({uc2, busy2, done2}), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #2;
        check("rst_uc", 32'(uc1), 32'd0);
        check("rst_flags", 32'({busy1, full1, overflow1, done1, timeout1}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        start = 1'b0; wr_en = 1'b0; lib_ack = 1'b0; lib_grant = 1'b0;
        model_q.delete();
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        if (model_q.size() < 16)
            model_q.push_back(b);
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        length = 16'(len);
        tick();
        start = 1'b0;
        check("start_uc_lag", 32'(uc1), 32'd0);
        check("start_busy", 32'(busy1), 32'd1);
        tick();
        check("req_bit", 32'(uc1[26]), 32'd1);
        check("req_addr", 32'(uc1[29:27]), 32'd1);
        check("req_len", 32'(uc1[23:8]), 32'(len));
    endtask

    // Plays the library: grants (after a random delay) and acks nacks bytes.
    task automatic serve(input int total, input int nacks);
        int left = total;
        int acked = 0;
        int budget = 400;
        int d;
        d = $urandom_range(0, 3);
        for (int i = 0; i < d && !lib_grant; i++) begin
            tick();
            check("req_hold", 32'(uc1[26]), 32'd1);
        end
        lib_grant = 1'b1;
        while (acked < nacks && budget > 0) begin
            if (uc1[25]) begin
                check("send_addr", 32'(uc1[29:27]), 32'd1);
                check("send_len", 32'(uc1[23:8]), 32'(total));
                check("send_req0", 32'(uc1[26]), 32'd0);
                check("send_data", 32'(uc1[7:0]), 32'(model_q[0]));
                check("send_last", 32'(uc1[24]), 32'(left == 1));
                d = $urandom_range(0, 2);
                for (int i = 0; i < d; i++) begin
                    tick();
                    check("hold_data", 32'({uc1[25], uc1[7:0]}), 32'({1'b1, model_q[0]}));
                end
                lib_ack = 1'b1;
                tick();
                lib_ack = 1'b0;
                void'(model_q.pop_front());
                left--;
                acked++;
                if (left == 0) begin
                    check("done_pulse", 32'(done1), 32'd1);
                    check("done_uc", 32'(uc1), 32'd0);
                end else begin
                    check("strobe_drop", 32'(uc1[25]), 32'd0);
                    check("no_done", 32'(done1), 32'd0);
                end
            end else begin
                tick();
                budget--;
            end
        end
        if (budget == 0)
            check("serve_budget", 32'(acked), 32'(nacks));
        if (left == 0) begin
            tick();
            check("after_done", 32'({done1, busy1}), 32'd0);
            check("after_uc", 32'(uc1), 32'd0);
        end
    endtask

    initial begin
        int sz, wc, len, j;
        logic found;

        // single transfer
        do_reset();
        wr(8'hA1); wr(8'hB2); wr(8'hC3);
        lib_grant = 1'b1;
        do_start(3);
        serve(3, 3);

        // underrun
        do_reset();
        lib_grant = 1'b1;
        do_start(2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("underrun_strobe", 32'(uc1[26:25]), 32'd0);
        end
        wr(8'h55); wr(8'h66);
        serve(2, 2);

        // overflow and ignored zero-length start
        do_reset();
        for (int i = 0; i < 15; i++) wr(8'(i * 7 + 3));
        check("full_15", 32'(full1), 32'd0);
        wr(8'hEE);
        check("full_16", 32'(full1), 32'd1);
        check("ovf_16", 32'(overflow1), 32'd0);
        wr(8'h99);
        check("ovf_17", 32'(overflow1), 32'd1);
        check("full_17", 32'(full1), 32'd1);
        start = 1'b1; length = 16'd0;
        tick();
        start = 1'b0;
        check("zero_start_busy", 32'(busy1), 32'd0);
        tick();
        check("zero_start_uc", 32'({busy1, uc1}), 32'd0);
        lib_grant = 1'b1;
        do_start(16);
        serve(16, 16);

        // mid-transfer reset
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'($urandom));
        lib_grant = 1'b1;
        do_start(3);
        serve(3, 1);
        wr(8'h42);
        check("refill_full", 32'(full1), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_uc", 32'(uc1), 32'd0);
        check("mid_rst_flags", 32'({busy1, full1, done1}), 32'd0);
        #2;
        RST = 1'b0;
        model_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_quiet", 32'({done1, busy1}), 32'd0);
        end

        // grant withheld
        do_reset();
        wr(8'h11); wr(8'h22); wr(8'h33);
        do_start(3);
`ifdef EPT_TX_TIMEOUT_EN
        j = 1;
        found = 1'b0;
        while (j < 20 && !found) begin
            tick();
            j++;
            if (timeout1) found = 1'b1;
        end
        check("tout_cycle", 32'(j), 32'd8);
        check("tout_uc", 32'({busy1, uc1}), 32'd0);
        tick();
        check("tout_pulse", 32'(timeout1), 32'd0);
        do_start(3);
        serve(3, 3);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout1 || !uc1[26])
                check("req_forever", 32'({timeout1, uc1[26]}), 32'd1);
        end
        check("req_wait_busy", 32'({busy1, timeout1}), 32'd2);
        serve(3, 3);
`endif

        // randomized transfers with leftover bytes carried over
        do_reset();
        for (int t = 0; t < 8; t++) begin
            sz = model_q.size();
            wc = $urandom_range(0, 16 - sz);
            if (sz + wc == 0) wc = 1;
            for (int i = 0; i < wc; i++) wr(8'($urandom));
            len = $urandom_range(1, model_q.size());
            lib_grant = 1'b0;
            do_start(len);
            serve(len, len);
            check("rand_ovf", 32'(overflow1), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
